// File: rtl/array8_sorter_pkg.sv
// Shared constants and index helpers for the
// eight-element bitonic sorter.
package array8_sorter_pkg;

  localparam int  DEF_WIDTH  = 4;
  localparam int  N_ELEM     = 8;
  localparam logic ASCENDING  = 1'b1;
  localparam logic DESCENDING = 1'b0;

  // Lower wire of comparator c in a stage of span j.
  function automatic int lo_idx(int c, int j);
    return (c / j) * 2 * j + (c % j);
  endfunction

  // Block of size k containing i sorts up when
  // its k bit is clear.
  function automatic logic dir_of(int i, int k);
    return ((i & k) == 0) ? ASCENDING : DESCENDING;
  endfunction

endpackage

// File: rtl/array8_sorter_comp_swap.sv
// Compare-exchange element: (min, max) when
// ascending, (max, min) when descending.
module comp_swap
  import array8_sorter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             direction,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  logic swap;

  assign swap = (direction == ASCENDING) ? (a > b) : (a < b);
  assign lo   = swap ? b : a;
  assign hi   = swap ? a : b;

endmodule

// File: rtl/array8_sorter.sv
// Eight-input bitonic sorting network with a
// single output register stage.
module array8_sorter
  import array8_sorter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] a2,
  input  logic [WIDTH-1:0] a3,
  input  logic [WIDTH-1:0] a4,
  input  logic [WIDTH-1:0] a5,
  input  logic [WIDTH-1:0] a6,
  input  logic [WIDTH-1:0] a7,
  output logic [WIDTH-1:0] z0,
  output logic [WIDTH-1:0] z1,
  output logic [WIDTH-1:0] z2,
  output logic [WIDTH-1:0] z3,
  output logic [WIDTH-1:0] z4,
  output logic [WIDTH-1:0] z5,
  output logic [WIDTH-1:0] z6,
  output logic [WIDTH-1:0] z7
);

  // One array per stage keeps the network acyclic
  logic [WIDTH-1:0] s0 [N_ELEM];
  logic [WIDTH-1:0] s1 [N_ELEM];
  logic [WIDTH-1:0] s2 [N_ELEM];
  logic [WIDTH-1:0] s3 [N_ELEM];
  logic [WIDTH-1:0] s4 [N_ELEM];
  logic [WIDTH-1:0] s5 [N_ELEM];
  logic [WIDTH-1:0] s6 [N_ELEM];
  logic [WIDTH-1:0] q  [N_ELEM];

  assign s0 = '{a0, a1, a2, a3, a4, a5, a6, a7};

  for (genvar c = 0; c < N_ELEM / 2; c++) begin : g_st0
    localparam int I = lo_idx(c, 1);
    comp_swap #(.WIDTH(WIDTH)) u_cs (
      .a(s0[I]), .b(s0[I+1]), .direction(dir_of(I, 2)),
      .lo(s1[I]), .hi(s1[I+1])
    );
  end

  for (genvar c = 0; c < N_ELEM / 2; c++) begin : g_st1
    localparam int I = lo_idx(c, 2);
    comp_swap #(.WIDTH(WIDTH)) u_cs (
      .a(s1[I]), .b(s1[I+2]), .direction(dir_of(I, 4)),
      .lo(s2[I]), .hi(s2[I+2])
    );
  end

  for (genvar c = 0; c < N_ELEM / 2; c++) begin : g_st2
    localparam int I = lo_idx(c, 1);
    comp_swap #(.WIDTH(WIDTH)) u_cs (
      .a(s2[I]), .b(s2[I+1]), .direction(dir_of(I, 4)),
      .lo(s3[I]), .hi(s3[I+1])
    );
  end

  for (genvar c = 0; c < N_ELEM / 2; c++) begin : g_st3
    localparam int I = lo_idx(c, 4);
    comp_swap #(.WIDTH(WIDTH)) u_cs (
      .a(s3[I]), .b(s3[I+4]), .direction(dir_of(I, 8)),
      .lo(s4[I]), .hi(s4[I+4])
    );
  end

  for (genvar c = 0; c < N_ELEM / 2; c++) begin : g_st4
    localparam int I = lo_idx(c, 2);
    comp_swap #(.WIDTH(WIDTH)) u_cs (
      .a(s4[I]), .b(s4[I+2]), .direction(dir_of(I, 8)),
      .lo(s5[I]), .hi(s5[I+2])
    );
  end

  for (genvar c = 0; c < N_ELEM / 2; c++) begin : g_st5
    localparam int I = lo_idx(c, 1);
    comp_swap #(.WIDTH(WIDTH)) u_cs (
      .a(s5[I]), .b(s5[I+1]), .direction(dir_of(I, 8)),
      .lo(s6[I]), .hi(s6[I+1])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_ELEM; i++) q[i] <= '0;
    end else begin
      for (int i = 0; i < N_ELEM; i++) q[i] <= s6[i];
    end
  end

  assign z0 = q[0];
  assign z1 = q[1];
  assign z2 = q[2];
  assign z3 = q[3];
  assign z4 = q[4];
  assign z5 = q[5];
  assign z6 = q[6];
  assign z7 = q[7];

endmodule

// File: tb/tb_array8_sorter.sv
// Directed and randomized checks of array8_sorter
// against a queue-sort reference model.
module tb_array8_sorter;

  localparam int W = 4;

  typedef int vec_t [8];

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] a [8];
  logic [W-1:0] z [8];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  array8_sorter #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .a0(a[0]), .a1(a[1]), .a2(a[2]), .a3(a[3]),
    .a4(a[4]), .a5(a[5]), .a6(a[6]), .a7(a[7]),
    .z0(z[0]), .z1(z[1]), .z2(z[2]), .z3(z[3]),
    .z4(z[4]), .z5(z[5]), .z6(z[6]), .z7(z[7])
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] zp();
    logic [31:0] r = '0;
    for (int i = 0; i < 8; i++) r[i*W +: W] = z[i];
    return r;
  endfunction

  function automatic logic [31:0] packv(input vec_t v);
    logic [31:0] r = '0;
    for (int i = 0; i < 8; i++) r[i*W +: W] = W'(v[i]);
    return r;
  endfunction

  function automatic logic [31:0] ref_sort(input vec_t v);
    int q[$];
    logic [31:0] r = '0;
    foreach (v[i]) q.push_back(v[i]);
    q.sort();
    for (int i = 0; i < 8; i++) r[i*W +: W] = W'(q[i]);
    return r;
  endfunction

  task automatic apply(input vec_t v);
    @(negedge clk);
    for (int i = 0; i < 8; i++) a[i] = W'(v[i]);
  endtask

  task automatic run(input string tag, input vec_t v,
                     input logic [31:0] exp);
    logic [31:0] prev;
    prev = zp();
    apply(v);
    #1 chk({tag, "_hold"}, zp(), prev);
    @(posedge clk);
    #1 chk(tag, zp(), exp);
  endtask

  initial begin
    vec_t v;
    vec_t rv;
    reset = 1'b0;
    rv = '{7, 3, 9, 1, 15, 0, 4, 2};
    for (int i = 0; i < 8; i++) a[i] = W'(rv[i]);
    #2 chk("rst_async", zp(), 32'h0);
    repeat (3) @(posedge clk);
    #1 chk("rst_clk", zp(), 32'h0);

    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 chk("rst_rel", zp(), packv('{0, 1, 2, 3, 4, 7, 9, 15}));

    run("rev", '{15, 14, 13, 12, 11, 10, 9, 8},
        packv('{8, 9, 10, 11, 12, 13, 14, 15}));
    run("sorted", '{1, 2, 3, 4, 5, 6, 7, 8},
        packv('{1, 2, 3, 4, 5, 6, 7, 8}));
    run("dups", '{5, 0, 5, 15, 0, 15, 5, 0},
        packv('{0, 0, 0, 5, 5, 5, 15, 15}));
    run("equal", '{6, 6, 6, 6, 6, 6, 6, 6},
        packv('{6, 6, 6, 6, 6, 6, 6, 6}));

    run("b2b0", '{9, 2, 14, 2, 0, 7, 15, 3},
        packv('{0, 2, 2, 3, 7, 9, 14, 15}));
    run("b2b1", '{0, 0, 0, 0, 15, 15, 15, 15},
        packv('{0, 0, 0, 0, 15, 15, 15, 15}));
    run("b2b2", '{15, 0, 15, 0, 15, 0, 15, 0},
        packv('{0, 0, 0, 0, 15, 15, 15, 15}));

    for (int n = 0; n < 10000; n++) begin
      for (int i = 0; i < 8; i++) begin
        if ($urandom_range(0, 7) == 0)
          v[i] = ($urandom_range(0, 1) == 0) ? 0 : 15;
        else
          v[i] = int'($urandom_range(0, 15));
      end
      run("rand", v, ref_sort(v));
    end

    @(posedge clk);
    #3 reset = 1'b0;
    #1 chk("rst_mid", zp(), 32'h0);
    @(posedge clk);
    #1 chk("rst_mid_hold", zp(), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    v = '{3, 12, 1, 1, 8, 0, 15, 6};
    for (int i = 0; i < 8; i++) a[i] = W'(v[i]);
    @(posedge clk);
    #1 chk("rst_mid_rel", zp(), ref_sort(v));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/array8_sorter.md
ARRAY8_SORTER -- requirements
Module: array8_sorter

Interface
REQ-001 Parameter WIDTH, default 4, bit width of every data element.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (low = reset asserted).
REQ-004 a0..a7  input  WIDTH each  eight unsigned elements to sort, sampled every cycle.
REQ-005 z0..z7  output  WIDTH each  registered sorted result; z0 smallest, z7 largest.
REQ-006 Port order: clk, reset, a0..a7, z0..z7; no other ports.

Function
REQ-007 The block SHALL sort a0..a7 in ascending unsigned order: z0 <= z1 <= ... <= z7.
REQ-008 Outputs SHALL be a permutation of the inputs sampled on the same edge; duplicates preserved with full multiplicity.
REQ-009 Sorting SHALL use an 8-input bitonic network: 3 merge levels, 6 compare-exchange stages, 24 compare-exchange elements, purely combinational between input ports and output register.
REQ-010 Compare-exchange: ascending element outputs (min, max); descending element outputs (max, min); comparison unsigned, full WIDTH.
REQ-011 Network construction: sort lower half (a0..a3) ascending and upper half (a4..a7) descending, then bitonic-merge all 8 ascending; recursively same for halves.
REQ-012 Equal operands: either order acceptable (values identical); no stability requirement.
REQ-013 Latency exactly 1 cycle: inputs present before rising edge N appear sorted on z0..z7 after edge N.
REQ-014 Throughput one new vector per cycle; no handshake, no stall, no valid flag.
REQ-015 Outputs SHALL hold between edges; no combinational path from a* to z*.
REQ-016 No arithmetic; no width growth; all-zero and all-ones (2^WIDTH-1) inputs handled like any other values.

Reset
REQ-017 While reset is low, z0..z7 SHALL be 0 immediately (asynchronous), independent of clk.
REQ-018 On reset release, first rising edge SHALL load the sorted current inputs; reset asserted mid-stream discards the in-flight result.
REQ-019 No other state exists; nothing else requires reset.

Structure
REQ-020 Shared package SHALL hold the WIDTH default, the element count (8) and direction constants ASCENDING=1/DESCENDING=0.
REQ-021 One sub-module, comp_swap (inputs a, b, direction; outputs lo/hi per REQ-010), instantiated 24 times; network wiring and output register in array8_sorter.

Verification
REQ-022 Reset: hold reset low, drive a=7,3,9,1,15,0,4,2 with clock running -> z0..z7 all 0; release -> after next edge z = 0,1,2,3,4,7,9,15.
REQ-023 Reverse input: a=15,14,13,12,11,10,9,8 -> after one edge z = 8,9,10,11,12,13,14,15; already-sorted input returns unchanged.
REQ-024 Duplicates/extremes: a=5,0,5,15,0,15,5,0 -> z = 0,0,0,5,5,5,15,15; all-equal a=6 -> all z=6.
REQ-025 Back-to-back: change vector every cycle for 3 cycles -> each output vector matches prior-cycle input, sorted, with 1-cycle latency and no bubbles.
REQ-026 Random: >=10000 random vectors compared against a reference sort (1-cycle delayed); plus asynchronous reset asserted between edges -> z goes 0 without waiting for clk.
